// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   loader_state_t   : loader FSM state encoding
//   DefaultDepth     : default instruction RAM depth in 32-bit words
//   DefaultSyncByte  : default frame start marker
//   DefaultIdxW      : word index width for the default depth
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCount,
    StData,
    StCksum,
    StDone,
    StErr
  } loader_state_t;

  localparam int unsigned DefaultDepth    = 64;
  localparam logic [7:0]  DefaultSyncByte = 8'hA5;
  localparam int unsigned DefaultIdxW     = $clog2(DefaultDepth);

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles little-endian 32-bit words from a byte stream.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : returns the lane counter to byte 0 (wins over byte_valid_i)
//   byte_valid_i  : byte_i is consumed this cycle
//   byte_i        : incoming byte
//   word_valid_o  : the consumed byte completes a word (lane 3)
//   word_o        : the completed word, valid while word_valid_o is high
module byte_packer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  lane_q, lane_d;
  // Holds bytes 0..2; byte 3 is taken straight from the input so the word is
  // available in the same cycle the last byte arrives.
  logic [23:0] sr_q, sr_d;

  always_comb begin
    lane_d = lane_q;
    sr_d   = sr_q;
    if (clr_i) begin
      lane_d = 2'd0;
    end else if (byte_valid_i) begin
      lane_d = lane_q + 2'd1;
      sr_d   = {byte_i, sr_q[23:8]};
    end
  end

  assign word_valid_o = byte_valid_i && !clr_i && (lane_q == 2'd3);
  assign word_o       = {byte_i, sr_q};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lane_q <= 2'd0;
      sr_q   <= 24'd0;
    end else begin
      lane_q <= lane_d;
      sr_q   <= sr_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: writes the instruction RAM from a framed byte stream and holds
// the core in reset until a complete, valid frame has been loaded.
// Frame: SYNC_BYTE, count N (1..DEPTH), 4N little-endian payload bytes, and,
// when IMEM_LOADER_CKSUM_EN is defined, a trailing XOR checksum byte covering
// the count and payload bytes.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_data    : byte stream input
//   in_ready            : high whenever out of reset (never back-pressures)
//   mem_we/addr/wdata   : single-cycle RAM write port, word-aligned byte address
//   core_hold           : keeps the core in reset while high
//   done / err          : sticky status of the last frame
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH     = DefaultDepth,
  parameter logic [7:0]  SYNC_BYTE = DefaultSyncByte
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_hold,
  output logic        done,
  output logic        err
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  loader_state_t   state_q, state_d;
  logic [7:0]      count_q, count_d;
  logic [IdxW-1:0] index_q, index_d;
  logic            ready_q;
  logic            mem_we_q, mem_we_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic            core_hold_q, core_hold_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]      cksum_q, cksum_d;
`endif

  logic        accept;
  logic        is_sync;
  logic        enter_count;
  logic        last_word;
  logic        pk_clr;
  logic        pk_valid;
  logic        word_valid;
  logic [31:0] word;

  assign accept    = in_valid && ready_q;
  assign is_sync   = (in_data == SYNC_BYTE);
  assign last_word = ((32'(index_q) + 32'd1) == 32'(count_q));

  // Lane counter is held at 0 outside DATA, so every frame starts aligned.
  assign pk_clr   = (state_q != StData);
  assign pk_valid = accept && (state_q == StData);

  byte_packer u_byte_packer (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clr_i        (pk_clr),
    .byte_valid_i (pk_valid),
    .byte_i       (in_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    index_d     = index_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    core_hold_d = core_hold_q;
    done_d      = done_q;
    err_d       = err_q;
    enter_count = 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
    cksum_d     = cksum_q;
`endif

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (accept && is_sync) begin
          enter_count = 1'b1;
        end
      end

      StCount: begin
        if (accept) begin
          count_d = in_data;
`ifdef IMEM_LOADER_CKSUM_EN
          cksum_d = in_data;
`endif
          if ((in_data == 8'd0) || (32'(in_data) > DEPTH)) begin
            state_d     = StErr;
            err_d       = 1'b1;
            done_d      = 1'b0;
            core_hold_d = 1'b1;
          end else begin
            state_d = StData;
            index_d = '0;
          end
        end
      end

      StData: begin
`ifdef IMEM_LOADER_CKSUM_EN
        if (accept) begin
          cksum_d = cksum_q ^ in_data;
        end
`endif
        if (word_valid) begin
          mem_we_d    = 1'b1;
          mem_wdata_d = word;
          mem_addr_d  = 32'(index_q) << 2;
          index_d     = index_q + 1'b1;
          if (last_word) begin
`ifdef IMEM_LOADER_CKSUM_EN
            state_d = StCksum;
`else
            state_d     = StDone;
            done_d      = 1'b1;
            err_d       = 1'b0;
            core_hold_d = 1'b0;
`endif
          end
        end
      end

`ifdef IMEM_LOADER_CKSUM_EN
      StCksum: begin
        if (accept) begin
          if (in_data == cksum_q) begin
            state_d     = StDone;
            done_d      = 1'b1;
            err_d       = 1'b0;
            core_hold_d = 1'b0;
          end else begin
            state_d     = StErr;
            err_d       = 1'b1;
            done_d      = 1'b0;
            core_hold_d = 1'b1;
          end
        end
      end
`endif

      default: begin
        state_d = StIdle;
      end
    endcase

    // A sync byte outside a frame starts a (re)load: status is invalidated and
    // the core is held until the new frame completes.
    if (enter_count) begin
      state_d     = StCount;
      done_d      = 1'b0;
      err_d       = 1'b0;
      core_hold_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      count_q     <= 8'd0;
      index_q     <= '0;
      ready_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      core_hold_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
      cksum_q     <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      index_q     <= index_d;
      ready_q     <= 1'b1;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      core_hold_q <= core_hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef IMEM_LOADER_CKSUM_EN
      cksum_q     <= cksum_d;
`endif
    end
  end

  assign in_ready  = ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign core_hold = core_hold_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: reset values, table-driven count-byte
// cases, hand-written timing sequences and randomized frames compared against
// a frame-level reference (expected RAM writes and final status).
module tb_imem_loader;

  localparam int unsigned Depth = 64;
  localparam logic [7:0]  Sync  = 8'hA5;
`ifdef IMEM_LOADER_CKSUM_EN
  localparam bit CkEn = 1'b1;
`else
  localparam bit CkEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_hold;
  logic        done;
  logic        err;

  imem_loader #(
    .DEPTH     (Depth),
    .SYNC_BYTE (Sync)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_hold (core_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] words [Depth];
  logic [63:0] wq [$];  // observed writes {addr, data}
  logic [63:0] eq [$];  // expected writes {addr, data}

  always @(negedge clk) begin
    if (mem_we) wq.push_back({mem_addr, mem_wdata});
  end

  typedef struct {
    logic [7:0] cnt;
    bit         ok;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Count byte, payload from words[], then checksum byte when enabled.
  task automatic send_body(input logic [7:0] cnt, input int nw, input bit gaps,
                           input bit bad_ck);
    logic [7:0] ck;
    logic [7:0] b;
    ck = cnt;
    send_byte(cnt);
    for (int w = 0; w < nw; w++) begin
      for (int l = 0; l < 4; l++) begin
        b  = words[w][8*l +: 8];
        ck = ck ^ b;
        if (gaps && ($urandom_range(3) == 0)) idle(1);
        send_byte(b);
      end
    end
    if (CkEn) begin
      if (gaps && ($urandom_range(3) == 0)) idle(1);
      send_byte(bad_ck ? (ck ^ 8'($urandom_range(1, 255))) : ck);
    end
  endtask

  task automatic expect_words(input int nw);
    for (int k = 0; k < nw; k++) eq.push_back({32'(k) << 2, words[k]});
  endtask

  task automatic check_writes(input string name);
    int n;
    idle(2);
    check({name, "_nwrites"}, 32'(wq.size()), 32'(eq.size()));
    n = (wq.size() < eq.size()) ? wq.size() : eq.size();
    for (int k = 0; k < n; k++) begin
      check({name, "_waddr"}, wq[k][63:32], eq[k][63:32]);
      check({name, "_wdata"}, wq[k][31:0], eq[k][31:0]);
    end
    wq.delete();
    eq.delete();
  endtask

  task automatic check_status(input string name, input bit ok);
    check({name, "_done"}, 32'(done), 32'(ok));
    check({name, "_err"}, 32'(err), 32'(!ok));
    check({name, "_hold"}, 32'(core_hold), 32'(!ok));
  endtask

  task automatic fill_random(input int nw);
    for (int k = 0; k < nw; k++) words[k] = $urandom;
  endtask

  initial begin
    vec_t        tab [6];
    logic [7:0]  seq [8];
    logic [7:0]  cnt;
    logic [7:0]  junk;
    int          nw;
    bit          bad_cnt;
    bit          bad_ck;

    tab[0] = '{cnt: 8'd1,  ok: 1'b1};
    tab[1] = '{cnt: 8'd0,  ok: 1'b0};
    tab[2] = '{cnt: 8'h41, ok: 1'b0};
    tab[3] = '{cnt: 8'hFF, ok: 1'b0};
    tab[4] = '{cnt: 8'd2,  ok: 1'b1};
    tab[5] = '{cnt: 8'd64, ok: 1'b1};

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_core_hold", 32'(core_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    #1;
    rst_n = 1'b1;
    idle(2);
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // Basic two-word frame with exact output timing.
    words[0] = 32'h0000_0013;
    words[1] = 32'h0010_0093;
    send_byte(Sync);
    send_byte(8'h02);
    for (int w = 0; w < 2; w++)
      for (int l = 0; l < 4; l++) send_byte(words[w][8*l +: 8]);
    check("t1_last_we", 32'(mem_we), 32'd1);
    check("t1_last_addr", mem_addr, 32'h4);
    check("t1_last_data", mem_wdata, 32'h0010_0093);
`ifdef IMEM_LOADER_CKSUM_EN
    check("t1_hold_before_ck", 32'(core_hold), 32'd1);
    check("t1_done_before_ck", 32'(done), 32'd0);
    send_byte(8'h92);
`endif
    check("t1_done", 32'(done), 32'd1);
    check("t1_hold", 32'(core_hold), 32'd0);
    expect_words(2);
    check_writes("t1");
    check_status("t1", 1'b1);

`ifdef IMEM_LOADER_CKSUM_EN
    // Wrong checksum: words land in RAM but the frame is rejected.
    send_byte(Sync);
    send_byte(8'h02);
    for (int w = 0; w < 2; w++)
      for (int l = 0; l < 4; l++) send_byte(words[w][8*l +: 8]);
    send_byte(8'h00);
    expect_words(2);
    check_writes("badck");
    check_status("badck", 1'b0);
`endif

    // Table-driven count byte cases, including both DEPTH boundaries.
    for (int i = 0; i < 6; i++) begin
      fill_random(Depth);
      send_byte(Sync);
      if (tab[i].ok) begin
        send_body(tab[i].cnt, int'(tab[i].cnt), 1'b0, 1'b0);
        expect_words(int'(tab[i].cnt));
      end else begin
        send_byte(tab[i].cnt);
      end
      check_writes($sformatf("tab%0d", i));
      check_status($sformatf("tab%0d", i), tab[i].ok);
    end

    // Sync hunting with in_valid toggling every other cycle.
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = Sync;  seq[3] = 8'h01;
    seq[4] = 8'hEF; seq[5] = 8'hBE; seq[6] = 8'hAD; seq[7] = 8'hDE;
    for (int i = 0; i < 8; i++) begin
      send_byte(seq[i]);
      check("hunt_ready", 32'(in_ready), 32'd1);
      idle(1);
    end
    if (CkEn) send_byte(8'h01 ^ 8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE);
    words[0] = 32'hDEAD_BEEF;
    expect_words(1);
    check_writes("hunt");
    check_status("hunt", 1'b1);

    // Reset in the middle of a frame.
    send_byte(Sync);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_we", 32'(mem_we), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd0);
    check("midrst_hold", 32'(core_hold), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    words[0] = 32'hCAFE_0001;
    send_byte(Sync);
    send_body(8'd1, 1, 1'b0, 1'b0);
    expect_words(1);
    check_writes("midrst");
    check_status("midrst", 1'b1);

    // Reload from DONE; status drops on the cycle after the sync byte.
    send_byte(Sync);
    check("reload_done", 32'(done), 32'd0);
    check("reload_hold", 32'(core_hold), 32'd1);
    check("reload_err", 32'(err), 32'd0);
    fill_random(Depth);
    send_body(8'd64, 64, 1'b0, 1'b0);
    check("reload_last_addr", mem_addr, 32'hFC);
    expect_words(64);
    check_writes("reload");
    check_status("reload", 1'b1);

    // Randomized frames with junk, gaps, bad counts and bad checksums.
    for (int it = 0; it < 24; it++) begin
      repeat ($urandom_range(0, 3)) begin
        junk = 8'($urandom);
        if (junk == Sync) junk = 8'h5A;
        send_byte(junk);
        if ($urandom_range(1) == 1) idle(1);
      end
      case ($urandom_range(0, 9))
        0: cnt = ($urandom_range(1) == 1) ? 8'd0 : 8'($urandom_range(65, 255));
        9: cnt = 8'd64;
        default: cnt = 8'($urandom_range(1, 12));
      endcase
      bad_cnt = (cnt == 8'd0) || (int'(cnt) > Depth);
      nw      = bad_cnt ? 0 : int'(cnt);
      bad_ck  = CkEn && !bad_cnt && ($urandom_range(0, 3) == 0);
      fill_random(Depth);
      send_byte(Sync);
      if (bad_cnt) send_byte(cnt);
      else send_body(cnt, nw, 1'b1, bad_ck);
      expect_words(nw);
      check_writes($sformatf("rnd%0d", it));
      check_status($sformatf("rnd%0d", it), !bad_cnt && !bad_ck);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
